// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory. It packs bytes little-endian into words and writes them at consecutive addresses.
// Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_hold;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_idx;
  logic [23:0]       r_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  state_t            w_state_nxt;
  logic              w_accept;
  logic [8:0]        w_byte_n;
  logic              w_count_ok;
  logic              w_last_word;

  assign w_accept    = in_valid && r_in_ready;
  // A COUNT byte of zero encodes a full-depth load.
  assign w_byte_n    = (in_byte == 8'd0) ? 9'(DEPTH) : {1'b0, in_byte};
  assign w_count_ok  = (w_byte_n <= 9'(DEPTH));
  assign w_last_word = ((r_words + (ADDR_W+1)'(1)) >= r_count);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_COUNT;
      S_COUNT: if (w_accept) w_state_nxt = w_count_ok ? S_DATA : S_ERROR;
      S_DATA:  if (w_accept && (r_idx == 2'd3)) w_state_nxt = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: w_state_nxt = w_last_word ? S_CHECK : S_DATA;
      S_CHECK: if (w_accept) w_state_nxt = (in_byte == r_xor) ? S_DONE : S_ERROR;
`else
      S_WRITE: w_state_nxt = w_last_word ? S_DONE : S_DATA;
`endif
      S_DONE:  if (start) w_state_nxt = S_COUNT;
      S_ERROR: if (start) w_state_nxt = S_COUNT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_asm      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_COUNT) || (w_state_nxt == S_DATA) ||
                    (w_state_nxt == S_CHECK);
      r_wr_en    <= (w_state_nxt == S_WRITE);
      r_hold     <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE));
      r_done     <= (w_state_nxt == S_DONE);
      r_error    <= (w_state_nxt == S_ERROR);

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_words <= '0;
            r_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        S_COUNT: begin
          if (w_accept) r_count <= w_byte_n[ADDR_W:0];
        end
        S_DATA: begin
          if (w_accept) begin
            r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ in_byte;
`endif
            case (r_idx)
              2'd0: r_asm[7:0]   <= in_byte;
              2'd1: r_asm[15:8]  <= in_byte;
              2'd2: r_asm[23:16] <= in_byte;
              default: begin
                r_wr_data <= {in_byte, r_asm};
                r_wr_addr <= BASE + r_words[ADDR_W-1:0];
              end
            endcase
          end
        end
        S_WRITE: r_words <= r_words + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_wr_en   = r_wr_en;
  assign imem_wr_addr = r_wr_addr;
  assign imem_wr_data = r_wr_data;
  assign cpu_hold     = r_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Expected writes go into a scoreboard queue as stimulus is driven and are compared on each write strobe.
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int BASE   = 30;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              CLOCK_50 = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_byte;
  logic              in_ready, imem_wr_en, cpu_hold, done, error;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         strobes  = 0;
  int         cyc      = 0;
  int         widx     = 0;
  int         c_start  = 0;
  int         c_end    = 0;
  int         s0       = 0;
  bit         stall_mode = 1'b0;
  logic [7:0] xor_acc  = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge CLOCK_50) begin
    wr_t e;
    if (imem_wr_en === 1'b1) begin
      strobes <= strobes + 1;
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wr_data), 64'(e.data));
      end
      check("ready_in_write", 64'(in_ready), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    if (stall_mode) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_byte  = b;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge CLOCK_50);
      acc = in_ready;
      tick();
    end
    check("byte_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back(wr_t'{addr: ADDR_W'((BASE + widx) % DEPTH), data: w});
    widx++;
    for (int k = 0; k < 4; k++) begin
      xor_acc = xor_acc ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic begin_load();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    widx     = 0;
    xor_acc  = 8'h00;
    c_start  = cyc;
  endtask

  task automatic wait_end();
    bit ok;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1 || error === 1'b1) begin
        ok    = 1'b1;
        c_end = cyc;
      end
    end
    check("end_reached", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(in_ready),     64'd0);
    check({tag, "_wr_en"}, 64'(imem_wr_en),   64'd0);
    check({tag, "_addr"},  64'(imem_wr_addr), 64'd0);
    check({tag, "_data"},  64'(imem_wr_data), 64'd0);
    check({tag, "_hold"},  64'(cpu_hold),     64'd0);
    check({tag, "_done"},  64'(done),         64'd0);
    check({tag, "_error"}, 64'(error),        64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic basic_stream();
    send_byte(8'h02);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_acc);
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // Basic load with continuous valid; also checks the minimum load time.
    begin_load();
    check("start_hold",  64'(cpu_hold), 64'd1);
    check("start_ready", 64'(in_ready), 64'd1);
    basic_stream();
    wait_end();
    check("basic_done",   64'(done),         64'd1);
    check("basic_error",  64'(error),        64'd0);
    check("basic_words",  64'(words_loaded), 64'd2);
    check("basic_hold",   64'(cpu_hold),     64'd0);
    check("basic_ready",  64'(in_ready),     64'd0);
    check("basic_cycles", 64'(c_end - c_start), 64'(1 + 5 * 2 + CK));
    check("basic_q",      64'(exp_q.size()), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words are written, then ERROR holds the CPU.
    begin_load();
    send_byte(8'h02);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    send_byte(xor_acc ^ 8'h01);
    wait_end();
    check("badck_error", 64'(error),        64'd1);
    check("badck_done",  64'(done),         64'd0);
    check("badck_hold",  64'(cpu_hold),     64'd1);
    check("badck_words", 64'(words_loaded), 64'd2);
    check("badck_q",     64'(exp_q.size()), 64'd0);
    begin_load();
    check("restart_error", 64'(error),    64'd0);
    check("restart_hold",  64'(cpu_hold), 64'd1);
`else
    begin_load();
    check("restart_done", 64'(done), 64'd0);
`endif

    // Illegal count goes straight to ERROR with no write strobe.
    s0 = strobes;
    send_byte(8'd33);
    wait_end();
    repeat (3) tick();
    check("illegal_error",   64'(error),        64'd1);
    check("illegal_done",    64'(done),         64'd0);
    check("illegal_hold",    64'(cpu_hold),     64'd1);
    check("illegal_ready",   64'(in_ready),     64'd0);
    check("illegal_words",   64'(words_loaded), 64'd0);
    check("illegal_strobes", 64'(strobes - s0), 64'd0);

    // Full depth (N=0) with the address wrapping past the top.
    begin_load();
    check("full_error_clr", 64'(error), 64'd0);
    s0 = strobes;
    send_byte(8'h00);
    for (int i = 0; i < DEPTH; i++) send_word((32'h0101_0101 * i) ^ 32'hC0DE_0000);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_acc);
`endif
    wait_end();
    check("full_done",    64'(done),          64'd1);
    check("full_words",   64'(words_loaded),  64'(DEPTH));
    check("full_strobes", 64'(strobes - s0),  64'(DEPTH));
    check("full_q",       64'(exp_q.size()),  64'd0);

    // Random valid gaps plus a start pulse in DATA that must be ignored.
    stall_mode = 1'b1;
    begin_load();
    send_byte(8'h02);
    send_word(32'h1122_3344);
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    send_word(32'hAABB_CCDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_acc);
`endif
    stall_mode = 1'b0;
    wait_end();
    check("stall_done",  64'(done),         64'd1);
    check("stall_error", 64'(error),        64'd0);
    check("stall_words", 64'(words_loaded), 64'd2);
    check("stall_q",     64'(exp_q.size()), 64'd0);

    // Reset after six data bytes: one word written, outputs back to reset values.
    begin_load();
    send_byte(8'h02);
    send_word(32'hCAFE_F00D);
    send_byte(8'h01);
    send_byte(8'h02);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    tick();
    check("midrst_q", 64'(exp_q.size()), 64'd0);

    begin_load();
    basic_stream();
    wait_end();
    check("reload_done",  64'(done),         64'd1);
    check("reload_error", 64'(error),        64'd0);
    check("reload_words", 64'(words_loaded), 64'd2);
    repeat (2) tick();
    check("final_q", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
